// File: rtl/div_pkg.sv
// Shared constants, divisor word type and wr_sel width helper for prog_clock_divider.
package div_pkg;

   localparam int unsigned DIV_WIDTH_DEFAULT = 32;
   localparam int unsigned MAX_CHANNELS      = 16;

   typedef logic [DIV_WIDTH_DEFAULT-1:0] div_word_t;

   localparam div_word_t DIV_RESET_DEFAULT = 32'd18;

   // Channel-select width: clog2 of the channel count, never below one bit.
   function automatic int unsigned sel_width(input int unsigned n);
      if (n <= 32'd1)
         return 32'd1;
      return 32'($clog2(n));
   endfunction

endpackage

// File: rtl/div_channel.sv
// One divider channel: pending/active divisor, counter, registered tick and square output.
module div_channel
   import div_pkg::*;
#(
   parameter int unsigned WIDTH       = DIV_WIDTH_DEFAULT,
   parameter div_word_t   DEFAULT_DIV = DIV_RESET_DEFAULT
) (
   input  logic             cin,
   input  logic             rst,
   input  logic             en,
   input  logic             sync,
   input  logic             wr,
   input  logic [WIDTH-1:0] wr_data,
   output logic             tick,
   output logic             cout
);

   localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DEFAULT_DIV);

   logic [WIDTH-1:0] pending;
   logic [WIDTH-1:0] active;
   logic [WIDTH-1:0] count;
   logic             tc;

   assign tc = (count == active);

   always_ff @(posedge cin or posedge rst) begin
      if (rst)
         pending <= RST_DIV;
      else if (wr)
         pending <= wr_data;
   end

   // active only ever samples the pre-write pending value, so a write landing on
   // a terminal count is deferred to the following terminal count.
   always_ff @(posedge cin or posedge rst) begin
      if (rst) begin
         active <= RST_DIV;
         count  <= '0;
         tick   <= 1'b0;
         cout   <= 1'b0;
      end else if (sync || !en) begin
         active <= pending;
         count  <= '0;
         tick   <= 1'b0;
         cout   <= 1'b0;
      end else if (tc) begin
         active <= pending;
         count  <= '0;
         tick   <= 1'b1;
         cout   <= ~cout;
      end else begin
         count  <= count + WIDTH'(1);
         tick   <= 1'b0;
      end
   end

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock-enable / square-wave generator.
// Optional feature macro: PHASE_SYNC_EN adds the sync phase-alignment input.
module prog_clock_divider
   import div_pkg::*;
#(
   parameter int unsigned WIDTH       = DIV_WIDTH_DEFAULT,
   parameter int unsigned CHANNELS    = 4,
   parameter div_word_t   DEFAULT_DIV = DIV_RESET_DEFAULT
) (
   input  logic                             cin,
   input  logic                             rst,
   input  logic [CHANNELS-1:0]              en,
   input  logic                             wr_en,
   input  logic [sel_width(CHANNELS)-1:0]   wr_sel,
   input  logic [WIDTH-1:0]                 wr_data,
`ifdef PHASE_SYNC_EN
   input  logic                             sync,
`endif
   output logic [CHANNELS-1:0]              tick,
   output logic [CHANNELS-1:0]              cout
);

   localparam int unsigned SW = sel_width(CHANNELS);

   logic sync_i;

`ifdef PHASE_SYNC_EN
   assign sync_i = sync;
`else
   assign sync_i = 1'b0;
`endif

   // Selects at or beyond CHANNELS match no channel and are silently dropped.
   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic wr_i;

      assign wr_i = wr_en && (wr_sel == SW'(i));

      div_channel #(
         .WIDTH       (WIDTH),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .cin     (cin),
         .rst     (rst),
         .en      (en[i]),
         .sync    (sync_i),
         .wr      (wr_i),
         .wr_data (wr_data),
         .tick    (tick[i]),
         .cout    (cout[i])
      );
   end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed self-checking bench for prog_clock_divider (optional PHASE_SYNC_EN scenario).
module tb_prog_clock_divider;

   logic       cin;
   logic       rst;
   logic [3:0] en;
   logic       wr_en;
   logic [1:0] wr_sel;
   logic [31:0] wr_data;
   logic       sync;
   logic [3:0] tick;
   logic [3:0] cout;

   logic [2:0] en8;
   logic       wr_en8;
   logic [1:0] wr_sel8;
   logic [7:0] wr_data8;
   logic [2:0] tick8;
   logic [2:0] cout8;

   int total = 0;
   int bad   = 0;

   prog_clock_divider u_dut (
      .cin     (cin),
      .rst     (rst),
      .en      (en),
      .wr_en   (wr_en),
      .wr_sel  (wr_sel),
      .wr_data (wr_data),
`ifdef PHASE_SYNC_EN
      .sync    (sync),
`endif
      .tick    (tick),
      .cout    (cout)
   );

   prog_clock_divider #(
      .WIDTH       (8),
      .CHANNELS    (3),
      .DEFAULT_DIV (32'd18)
   ) u_dut8 (
      .cin     (cin),
      .rst     (rst),
      .en      (en8),
      .wr_en   (wr_en8),
      .wr_sel  (wr_sel8),
      .wr_data (wr_data8),
`ifdef PHASE_SYNC_EN
      .sync    (sync),
`endif
      .tick    (tick8),
      .cout    (cout8)
   );

   initial begin
      cin = 1'b0;
      forever #5 cin = ~cin;
   end

   task automatic step();
      @(posedge cin);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_tick(input int ch, input int limit, output int cycles);
      int i;
      i = 0;
      cycles = -1;
      while (cycles < 0 && i < limit) begin
         i++;
         step();
         if (tick[ch] === 1'b1) cycles = i;
      end
   endtask

   task automatic do_write(input logic [1:0] sel, input logic [31:0] data);
      wr_en   = 1'b1;
      wr_sel  = sel;
      wr_data = data;
      step();
      wr_en   = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      en = '0; wr_en = 1'b0; wr_sel = '0; wr_data = '0; sync = 1'b0;
      en8 = '0; wr_en8 = 1'b0; wr_sel8 = '0; wr_data8 = '0;
      steps(2);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (tick !== 4'b0 || cout !== 4'b0) begin
         bad++;
         $display("FAIL reset_outputs: tick=%b cout=%b expected 0000/0000", tick, cout);
      end
      total++;
      if (tick8 !== 3'b0 || cout8 !== 3'b0) begin
         bad++;
         $display("FAIL reset_outputs8: tick=%b cout=%b expected 000/000", tick8, cout8);
      end
   endtask

   task automatic test_reset_default();
      int c;
      int highs;
      int ticks;
      logic other;
      do_reset();
      en = 4'b0001;
      wait_tick(0, 40, c);
      total++;
      if (c !== 19) begin
         bad++;
         $display("FAIL default_first_tick: got %0d cycles expected 19", c);
      end
      total++;
      if (cout[0] !== 1'b1) begin
         bad++;
         $display("FAIL default_cout_rise: cout0=%b expected 1", cout[0]);
      end
      highs = 0; ticks = 0; other = 1'b0;
      for (int i = 0; i < 38; i++) begin
         step();
         if (cout[0] === 1'b1) highs++;
         if (tick[0] === 1'b1) ticks++;
         other = other | (|tick[3:1]) | (|cout[3:1]);
      end
      total++;
      if (highs !== 19 || ticks !== 2) begin
         bad++;
         $display("FAIL default_square: highs=%0d ticks=%0d expected 19/2", highs, ticks);
      end
      total++;
      if (other !== 1'b0) begin
         bad++;
         $display("FAIL default_idle_channels: activity=%b expected 0", other);
      end
   endtask

   task automatic test_write_running();
      int c;
      do_reset();
      en = 4'b0010;
      wait_tick(1, 40, c);
      steps(5);
      do_write(2'd1, 32'd3);
      wait_tick(1, 40, c);
      total++;
      if (c !== 13) begin
         bad++;
         $display("FAIL write_running_tail: got %0d cycles expected 13", c);
      end
      for (int k = 0; k < 2; k++) begin
         wait_tick(1, 40, c);
         total++;
         if (c !== 4) begin
            bad++;
            $display("FAIL write_running_period%0d: got %0d cycles expected 4", k, c);
         end
      end
   endtask

   task automatic test_d0();
      do_reset();
      do_write(2'd2, 32'd0);
      step();
      en = 4'b0100;
      for (int i = 1; i <= 6; i++) begin
         step();
         total++;
         if (tick[2] !== 1'b1 || cout[2] !== ((i % 2) == 1)) begin
            bad++;
            $display("FAIL d0_cycle%0d: tick=%b cout=%b expected 1/%b", i, tick[2], cout[2], (i % 2) == 1);
         end
      end
      en = 4'b0000;
      step();
      total++;
      if (tick[2] !== 1'b0 || cout[2] !== 1'b0) begin
         bad++;
         $display("FAIL d0_disable: tick=%b cout=%b expected 0/0", tick[2], cout[2]);
      end
   endtask

   task automatic test_large();
      int c;
      do_reset();
      wr_en8 = 1'b1; wr_sel8 = 2'd3; wr_data8 = 8'd0;
      step();
      wr_sel8 = 2'd0; wr_data8 = 8'd255;
      step();
      wr_en8 = 1'b0;
      step();
      en8 = 3'b011;
      for (int k = 0; k < 2; k++) begin
         c = -1;
         for (int i = 1; i <= 300; i++) begin
            if (c < 0) begin
               step();
               if (tick8[0] === 1'b1) c = i;
            end
         end
         total++;
         if (c !== 256) begin
            bad++;
            $display("FAIL large_period%0d: got %0d cycles expected 256", k, c);
         end
         total++;
         if (cout8[0] !== (k == 0)) begin
            bad++;
            $display("FAIL large_cout%0d: cout=%b expected %b", k, cout8[0], k == 0);
         end
      end
      en8 = 3'b010;
      step();
      c = -1;
      for (int i = 1; i <= 40; i++) begin
         if (c < 0) begin
            step();
            if (tick8[1] === 1'b1) c = i;
         end
      end
      total++;
      if (c !== 19) begin
         bad++;
         $display("FAIL ignored_sel_write: ch1 first tick after %0d cycles expected 19", c);
      end
   endtask

   task automatic test_collision();
      int c;
      do_reset();
      en = 4'b0001;
      wait_tick(0, 40, c);
      steps(18);
      do_write(2'd0, 32'd5);
      total++;
      if (tick[0] !== 1'b1) begin
         bad++;
         $display("FAIL collision_edge_tick: tick0=%b expected 1", tick[0]);
      end
      wait_tick(0, 40, c);
      total++;
      if (c !== 19) begin
         bad++;
         $display("FAIL collision_next: got %0d cycles expected 19", c);
      end
      for (int k = 0; k < 2; k++) begin
         wait_tick(0, 40, c);
         total++;
         if (c !== 6) begin
            bad++;
            $display("FAIL collision_after%0d: got %0d cycles expected 6", k, c);
         end
      end
   endtask

   task automatic test_reset_mid();
      int c;
      do_reset();
      en = 4'b0001;
      wait_tick(0, 40, c);
      steps(10);
      do_write(2'd0, 32'd4);
      wait_tick(0, 40, c);
      rst = 1'b1;
      #1;
      total++;
      if (tick !== 4'b0 || cout !== 4'b0) begin
         bad++;
         $display("FAIL reset_async: tick=%b cout=%b expected 0000/0000", tick, cout);
      end
      rst = 1'b0;
      wait_tick(0, 40, c);
      total++;
      if (c !== 19) begin
         bad++;
         $display("FAIL reset_restart: got %0d cycles expected 19", c);
      end
   endtask

`ifdef PHASE_SYNC_EN
   task automatic test_sync();
      int c;
      do_reset();
      do_write(2'd0, 32'd7);
      do_write(2'd3, 32'd7);
      step();
      en = 4'b0001;
      steps(3);
      en = 4'b1001;
      steps(5);
      sync = 1'b1;
      step();
      sync = 1'b0;
      total++;
      if (tick !== 4'b0 || cout !== 4'b0) begin
         bad++;
         $display("FAIL sync_clear: tick=%b cout=%b expected 0000/0000", tick, cout);
      end
      for (int k = 0; k < 2; k++) begin
         wait_tick(0, 20, c);
         total++;
         if (c !== 8 || tick[3] !== 1'b1) begin
            bad++;
            $display("FAIL sync_phase%0d: cycles=%0d tick3=%b expected 8/1", k, c, tick[3]);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_reset_default();
      test_write_running();
      test_d0();
      test_large();
      test_collision();
      test_reset_mid();
`ifdef PHASE_SYNC_EN
      test_sync();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
